// File: rtl/fixed_point_sub_seq.sv
// ---------------------------------------------------------------------------
// fixed_point_sub_seq
//
// Purpose:
//   Sequential sign-magnitude subtractor computing C = A - B.
//   One operation passes through four states:
//     IDLE -> CMP -> EXEC -> DONE
//   The operands are captured in IDLE. The signs and magnitudes are compared
//   in CMP. The result is formed and registered in EXEC. DONE holds the
//   result until the consumer takes it with a valid/ready handshake.
//   A same-sign sum that overflows the magnitude field saturates to all ones
//   and raises ovf. Every zero-magnitude result is emitted as positive zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair A/B valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   A          minuend, sign-magnitude, BITSIZE bits
//   B          subtrahend, sign-magnitude, BITSIZE bits
//   out_valid  result C/ovf valid (DONE state)
//   out_ready  consumer accepts the result
//   C          registered result A-B, sign-magnitude
//   ovf        registered saturation flag for the current C
// ---------------------------------------------------------------------------
module fixed_point_sub_seq #(
    parameter int BITSIZE = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] A,
    input  logic [BITSIZE-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] C,
    output logic               ovf
);

    // Width of the magnitude field; bit MW of a word is its sign.
    localparam int MW = BITSIZE - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [BITSIZE-1:0] r_a;
    logic [BITSIZE-1:0] r_b;
    logic               r_effSignB;
    logic               r_signsEq;
    logic               r_aGreater;
    logic               r_magEq;

    logic [BITSIZE-1:0] r_c;
    logic               r_ovf;

    logic               w_accept;
    logic [MW-1:0]      w_magA;
    logic [MW-1:0]      w_magB;
    logic [BITSIZE-1:0] w_sum;
    logic [MW-1:0]      w_resMag;
    logic               w_resSign;
    logic               w_resOvf;
    logic [BITSIZE-1:0] w_resWord;

    // in_ready depends on rst combinationally. This keeps it low during
    // every reset cycle, even when the state register already holds IDLE.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;

    assign C   = r_c;
    assign ovf = r_ovf;

    // The magnitude fields of the captured operands. A negative zero has a
    // magnitude of 0, so it behaves exactly like a positive zero from here on.
    assign w_magA = r_a[MW-1:0];
    assign w_magB = r_b[MW-1:0];

    // The sum is one bit wider than a magnitude. Bit MW is the carry that
    // signals saturation.
    assign w_sum = {1'b0, w_magA} + {1'b0, w_magB};

    // Next-state logic. Only IDLE and DONE wait on a handshake.
    // CMP and EXEC each last exactly one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_nextState = CMP;
            CMP:     w_nextState = EXEC;
            EXEC:    w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Result datapath, driven by the flags registered in CMP.
    // - Same effective signs: add the magnitudes, and saturate on carry.
    // - Different signs: subtract the smaller magnitude from the larger one.
    //   The result takes the sign of the larger operand.
    always_comb begin
        w_resMag  = '0;
        w_resSign = 1'b0;
        w_resOvf  = 1'b0;
        if (r_signsEq) begin
            w_resSign = r_a[MW];
            if (w_sum[MW]) begin
                w_resMag = '1;
                w_resOvf = 1'b1;
            end else begin
                w_resMag = w_sum[MW-1:0];
            end
        end else if (r_magEq) begin
            w_resMag  = '0;
            w_resSign = 1'b0;
        end else if (r_aGreater) begin
            w_resMag  = w_magA - w_magB;
            w_resSign = r_a[MW];
        end else begin
            w_resMag  = w_magB - w_magA;
            w_resSign = r_effSignB;
        end
    end

    // Force a positive zero whenever the magnitude is zero.
    // For example, (-0) - (+0) must not produce a negative zero.
    assign w_resWord = {(w_resMag != '0) ? w_resSign : 1'b0, w_resMag};

    // State register and datapath registers. Reset discards any operation
    // in flight. No result is presented afterwards, because out_valid comes
    // only from the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_effSignB <= 1'b0;
            r_signsEq  <= 1'b0;
            r_aGreater <= 1'b0;
            r_magEq    <= 1'b0;
            r_c        <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a <= A;
                        r_b <= B;
                    end
                end
                CMP: begin
                    r_effSignB <= ~r_b[MW];
                    r_signsEq  <= (r_a[MW] == ~r_b[MW]);
                    r_aGreater <= (w_magA > w_magB);
                    r_magEq    <= (w_magA == w_magB);
                end
                EXEC: begin
                    r_c   <= w_resWord;
                    r_ovf <= w_resOvf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_fixed_point_sub_seq
//
// Purpose:
//   Directed testbench for fixed_point_sub_seq at the default BITSIZE of 20.
//   Every expected result below was computed by hand in sign-magnitude.
// ---------------------------------------------------------------------------
module tb_fixed_point_sub_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] A;
    logic [19:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] C;
    logic        ovf;

    int checks;
    int failures;

    fixed_point_sub_seq #(.BITSIZE(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns so the outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one operand pair and let the accepting edge pass.
    task automatic applyStimulus(input string tag, input logic [19:0] a,
                                 input logic [19:0] b);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid rises.
    // The count is bounded, so a stuck design still reaches the summary.
    task automatic waitResult(output int edges);
        edges = 0;
        while (!out_valid && edges < 10) begin
            tick();
            edges++;
        end
    endtask

    // Run one full operation with out_ready high.
    // Counting the accepting edge as the first, out_valid is high after the
    // third edge. That is two edges after the edge that accepted the operands.
    task automatic runVector(input string tag, input logic [19:0] a,
                             input logic [19:0] b, input logic [19:0] expC,
                             input logic expOvf);
        int lat;
        out_ready = 1'b1;
        applyStimulus(tag, a, b);
        waitResult(lat);
        checkOutput({tag, " latency"},  32'(lat),       32'd2);
        checkOutput({tag, " C"},        32'(C),         32'(expC));
        checkOutput({tag, " ovf"},      32'(ovf),       32'(expOvf));
        checkOutput({tag, " in_ready"}, 32'(in_ready),  32'd0);
        tick();
        checkOutput({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " in_ready after handshake"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [19:0] bbA [3];
        logic [19:0] bbB [3];
        logic [19:0] bbC [3];
        int          acceptCycle [3];
        int          inIdx;
        int          outIdx;
        int          cyc;
        int          lat;
        logic        willAccept;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;

        // Reset state. in_valid is held high so we can see that rst wins.
        in_valid = 1'b1;
        tick();
        tick();
        checkOutput("reset in_ready",  32'(in_ready),  32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset C",         32'(C),         32'd0);
        checkOutput("reset ovf",       32'(ovf),       32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        checkOutput("in_ready after reset release", 32'(in_ready), 32'd1);

        // Directed vectors.
        runVector("pos minus smaller pos", 20'h10000, 20'h08000, 20'h08000, 1'b0);
        runVector("pos minus larger pos",  20'h20000, 20'h60000, 20'hC0000, 1'b0);
        runVector("equal magnitudes",      20'h40000, 20'h40000, 20'h00000, 1'b0);
        runVector("neg zero minus zero",   20'h80000, 20'h00000, 20'h00000, 1'b0);
        runVector("pos overflow",          20'h7FFFF, 20'h80001, 20'h7FFFF, 1'b1);
        runVector("neg overflow",          20'hC0000, 20'h40000, 20'hFFFFF, 1'b1);
        runVector("max plus neg zero",     20'h7FFFF, 20'h80000, 20'h7FFFF, 1'b0);
        runVector("neg minus larger neg",  20'h80100, 20'h80300, 20'h00200, 1'b0);
        runVector("one minus minus two",   20'h00001, 20'h80002, 20'h00003, 1'b0);
        runVector("neg zero minus pos",    20'h80000, 20'h00010, 20'h80010, 1'b0);

        // Backpressure: DONE must hold C/ovf/out_valid and ignore new operands.
        out_ready = 1'b0;
        applyStimulus("backpressure", 20'h10000, 20'h08000);
        waitResult(lat);
        checkOutput("backpressure latency", 32'(lat), 32'd2);
        in_valid = 1'b1;
        A        = 20'h00123;
        B        = 20'h80456;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("backpressure out_valid held", 32'(out_valid), 32'd1);
            checkOutput("backpressure C held",         32'(C),         32'h08000);
            checkOutput("backpressure ovf held",       32'(ovf),       32'd0);
            checkOutput("backpressure in_ready low",   32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("backpressure release in_ready",  32'(in_ready),  32'd1);
        checkOutput("backpressure release out_valid", 32'(out_valid), 32'd0);

        // Reset while in EXEC discards the operation.
        applyStimulus("reset in EXEC", 20'h00005, 20'h00003);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("in_ready during reset", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("post-reset C",         32'(C),         32'd0);
        checkOutput("post-reset ovf",       32'(ovf),       32'd0);
        checkOutput("post-reset in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("no result after reset", 32'(out_valid), 32'd0);
        end

        // Back-to-back: in_valid held high, three pairs, results in order.
        bbA[0] = 20'h00010; bbB[0] = 20'h00004; bbC[0] = 20'h0000C;
        bbA[1] = 20'h80020; bbB[1] = 20'h00005; bbC[1] = 20'h80025;
        bbA[2] = 20'h00003; bbB[2] = 20'h00009; bbC[2] = 20'h80006;
        inIdx     = 0;
        outIdx    = 0;
        cyc       = 0;
        out_ready = 1'b1;
        A         = bbA[0];
        B         = bbB[0];
        in_valid  = 1'b1;
        while (cyc < 30 && outIdx < 3) begin
            if (out_valid) begin
                checkOutput($sformatf("back-to-back C[%0d]", outIdx), 32'(C), 32'(bbC[outIdx]));
                outIdx++;
            end
            willAccept = in_ready && in_valid;
            if (willAccept) acceptCycle[inIdx] = cyc;
            tick();
            cyc++;
            if (willAccept) begin
                inIdx++;
                if (inIdx < 3) begin
                    A = bbA[inIdx];
                    B = bbB[inIdx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checkOutput("back-to-back result count", 32'(outIdx), 32'd3);
        checkOutput("back-to-back accept count", 32'(inIdx),  32'd3);
        if (inIdx == 3) begin
            checkOutput("back-to-back interval 0-1", 32'(acceptCycle[1] - acceptCycle[0]), 32'd4);
            checkOutput("back-to-back interval 1-2", 32'(acceptCycle[2] - acceptCycle[1]), 32'd4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
